// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: request/grant bus between the requesters and the shared tick timer.
//   tick      : one-cycle divider pulse, counted only while a countdown runs
//   req       : per-requester request level, held until done
//   delay     : packed per-requester delays, requester i at [i*DW +: DW]
//   grant     : one-hot owner of the timer, zero when idle
//   done      : one-hot single-cycle completion pulse to the owner
//   busy      : high whenever grant is non-zero
//   remaining : current countdown value, zero when idle
interface tick_scheduler_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic                 tick;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   delay;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      done;
    logic                 busy;
    logic [DW-1:0]        remaining;
    modport master (output tick, req, delay, input grant, done, busy, remaining);
    modport slave (input tick, req, delay, output grant, done, busy, remaining);
endinterface

// File: rtl/tick_scheduler.sv
// tick_scheduler: round-robin sharing of one tick-driven countdown timer among NREQ requesters.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, aborts any countdown without a done pulse
//   bus : tick_scheduler_if slave (tick/req/delay in, grant/done/busy/remaining out)
module tick_scheduler #(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    tick_scheduler_if.slave  bus
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, own_q, own_d, win, idx, nxt;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   dly [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_dly
        assign dly[g] = bus.delay[g*DW +: DW];
    end
    // Scan from ptr downward in priority so the first set bit at or after ptr wins last.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr_q) + k) % NREQ);
            win = bus.req[idx] ? idx : win;
        end
    end
    assign nxt = (own_q == IW'(NREQ - 1)) ? '0 : own_q + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (|bus.req) begin
                own_d   = win;
                cnt_d   = dly[win];
                state_d = COUNT;
            end
            COUNT: if (!bus.req[own_q]) begin
                cnt_d   = '0;
                ptr_d   = nxt;
                state_d = IDLE;
            end else if (cnt_q == '0) begin
                state_d = DONE;
            end else if (bus.tick) begin
                cnt_d = cnt_q - 1'b1;
            end
            DONE: begin
                ptr_d   = nxt;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // Outputs depend only on registered state, so nothing combinational reaches them from inputs.
    always_comb begin
        bus.grant     = (state_q != IDLE) ? NREQ'(1) << own_q : '0;
        bus.done      = (state_q == DONE) ? NREQ'(1) << own_q : '0;
        bus.busy      = state_q != IDLE;
        bus.remaining = cnt_q;
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed checks of grant order, countdown, done timing, cancel and reset.
module tb_tick_scheduler;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    tick_scheduler_if #(.NREQ(4), .DW(8)) bus ();
    tick_scheduler #(.NREQ(4), .DW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic cyc();
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [3:0] g, input logic [3:0] d, input logic [7:0] r);
        logic [16:0] obs;
        logic [16:0] exp;
        obs = {bus.grant, bus.done, bus.busy, bus.remaining};
        exp = {g, d, |g, r};
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.tick = 1'b0;
        bus.delay = {8'd2, 8'd2, 8'd2, 8'd2};
        cyc();
        for (int i = 0; i < 3; i++) begin
            bus.tick = ~bus.tick;
            cyc();
            chk("reset_hold", 4'b0000, 4'b0000, 8'd0);
        end
        rst = 1'b0;
        bus.tick = 1'b0;
        cyc();
        chk("first_grant", 4'b0001, 4'b0000, 8'd2);
        bus.req = 4'b0000;
        cyc();
        chk("cancel0", 4'b0000, 4'b0000, 8'd0);
        bus.req = 4'b0100;
        bus.delay = {8'd0, 8'd3, 8'd0, 8'd0};
        cyc();
        chk("single_grant", 4'b0100, 4'b0000, 8'd3);
        for (int n = 3; n >= 1; n--) begin
            bus.tick = 1'b0;
            repeat (3) cyc();
            chk("single_hold", 4'b0100, 4'b0000, 8'(n));
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
            chk("single_dec", 4'b0100, 4'b0000, 8'(n - 1));
        end
        cyc();
        chk("single_done", 4'b0100, 4'b0100, 8'd0);
        bus.req = 4'b0000;
        cyc();
        chk("single_idle", 4'b0000, 4'b0000, 8'd0);
        bus.req = 4'b0001;
        bus.delay = '0;
        cyc();
        chk("zero_grant", 4'b0001, 4'b0000, 8'd0);
        cyc();
        chk("zero_done", 4'b0001, 4'b0001, 8'd0);
        bus.req = 4'b0000;
        cyc();
        chk("zero_idle", 4'b0000, 4'b0000, 8'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req = 4'b1111;
        bus.delay = {8'd1, 8'd1, 8'd1, 8'd1};
        bus.tick = 1'b1;
        for (int s = 0; s < 5; s++) begin
            logic [3:0] g;
            g = 4'b0001 << (s % 4);
            cyc();
            chk("rr_grant", g, 4'b0000, 8'd1);
            cyc();
            chk("rr_count", g, 4'b0000, 8'd0);
            cyc();
            chk("rr_done", g, g, 8'd0);
            cyc();
            chk("rr_gap", 4'b0000, 4'b0000, 8'd0);
        end
        bus.req = 4'b0010;
        bus.delay = {8'd5, 8'd5, 8'd5, 8'd5};
        bus.tick = 1'b0;
        cyc();
        chk("cxl_grant", 4'b0010, 4'b0000, 8'd5);
        bus.tick = 1'b1;
        cyc();
        chk("cxl_tick1", 4'b0010, 4'b0000, 8'd4);
        cyc();
        chk("cxl_tick2", 4'b0010, 4'b0000, 8'd3);
        bus.tick = 1'b0;
        bus.req = 4'b0000;
        cyc();
        chk("cxl_drop", 4'b0000, 4'b0000, 8'd0);
        bus.req = 4'b0101;
        cyc();
        chk("cxl_next", 4'b0100, 4'b0000, 8'd5);
        bus.tick = 1'b1;
        cyc();
        chk("mid_count", 4'b0100, 4'b0000, 8'd4);
        rst = 1'b1;
        cyc();
        chk("mid_reset", 4'b0000, 4'b0000, 8'd0);
        rst = 1'b0;
        bus.req = 4'b0000;
        bus.tick = 1'b0;
        cyc();
        chk("mid_after", 4'b0000, 4'b0000, 8'd0);
        bus.req = 4'b0001;
        bus.tick = 1'b1;
        cyc();
        chk("tick_at_grant", 4'b0001, 4'b0000, 8'd5);
        bus.tick = 1'b0;
        bus.delay = {8'd9, 8'd9, 8'd9, 8'd9};
        cyc();
        chk("delay_change", 4'b0001, 4'b0000, 8'd5);
        bus.req = 4'b0000;
        cyc();
        chk("final_idle", 4'b0000, 4'b0000, 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Round-robin scheduler that shares one tick-driven countdown timer among NREQ requesters. It sits downstream of the clock-divider tick generator: each requester asks for a delay of D prescaler ticks, the scheduler grants the single timer to one requester at a time, counts D ticks, then pulses that requester's done line. It lets several slow-timed functions share one prescaler and one counter.

## Interface
- NREQ, 4: number of requesters (2..8).
- DW, 8: delay width in ticks; maximum delay 2^DW-1.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle pulse from the divider; counted only in COUNT.
- req  in  NREQ  per-requester request level; must be held until done, and dropping it cancels.
- delay  in  NREQ*DW  packed delays; requester i uses bits [i*DW +: DW], sampled only at grant.
- grant  out  NREQ  one-hot owner of the timer; all-zero when idle.
- done  out  NREQ  one-hot, one-cycle completion pulse to the owner.
- busy  out  1  high whenever grant is non-zero.
- remaining  out  DW  current countdown value; 0 when idle.

## Operation
- Reset values: all outputs are 0. The internal state is IDLE, the round-robin pointer ptr is 0, and cnt is 0.
- Reset behaviour:
  - Reset is synchronous and overrides everything, including an in-progress COUNT.
  - No done pulse is emitted for an aborted delay.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - If req is non-zero, select the winner: the first set bit scanning ptr, ptr+1, …, NREQ-1, then 0, …, ptr-1.
  - Register grant to the winner's one-hot value.
  - Load cnt with delay[winner].
  - Go to COUNT.
  - If req is zero, stay in IDLE.
- COUNT, evaluated in priority order:
  - (1) If req[owner] is 0, cancel: clear grant and cnt, set ptr to owner+1 (mod NREQ), go to IDLE, and pulse no done.
  - (2) Else if cnt is 0, go to DONE.
  - (3) Else if tick is 1, decrement cnt.
  - (4) Else hold.
- DONE:
  - done[owner] is high for exactly this one cycle, and grant is still asserted during it.
  - On the next edge: clear grant, set ptr to owner+1 (mod NREQ), go to IDLE.
- Delay semantics:
  - D=0 completes without waiting for any tick.
  - D>0 completes after the D-th tick observed in COUNT.
  - A tick arriving in the IDLE cycle that grants is not counted.
  - A tick arriving in the DONE cycle is ignored.
- Changes to delay while a requester is granted are ignored.
- Non-owner req bits are only examined in IDLE.
- remaining mirrors cnt. busy equals the OR of all grant bits.

## Timing
- Grant latency: req sampled high in IDLE at edge t gives grant high after edge t (cycle t+1).
- D=0: grant at cycle t+1 (COUNT), done at cycle t+2 (DONE), grant low at cycle t+3.
- D>0: done is asserted in the cycle after the COUNT cycle in which cnt becomes 0 is observed. That is 2 cycles after the edge that consumes the D-th tick.
- Back-to-back grants: after DONE there is at least one IDLE cycle with grant=0 before the next grant.
- Throughput: each service is D ticks plus 3 cycles of overhead when no cancellation occurs.
- Fairness: a continuously requesting requester waits at most NREQ-1 other services.
- ptr advances only on completion or cancellation, never in IDLE without a grant.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset check:
  - Stimulus: hold rst for 3 cycles while req=4'b1111 and tick toggles.
  - Required response: grant, done, busy and remaining stay 0. After rst releases, the first grant is 4'b0001 (ptr=0).
- Single delay:
  - Stimulus: req=4'b0100, delay[2]=3, tick every 4th cycle.
  - Required response: grant=4'b0100 one cycle after req. remaining steps 3→2→1→0 on ticks. done=4'b0100 for exactly one cycle, 2 cycles after the 3rd tick. grant then drops.
- Zero delay:
  - Stimulus: req=4'b0001, delay[0]=0, tick=0 throughout.
  - Required response: grant in cycle t+1, done in cycle t+2, idle in cycle t+3.
- Round-robin:
  - Stimulus: req=4'b1111 held, all delays=1, free-running tick.
  - Required response: grants in the order 0001, 0010, 0100, 1000, 0001, each with exactly one done and an idle gap between them.
- Cancellation:
  - Stimulus: grant requester 1 with delay=5, then drop req[1] after 2 ticks.
  - Required response: grant clears the next cycle with no done pulse and remaining=0. The next grant goes to requester 2 or later before requester 0.
- Mid-operation reset and tick coincidence:
  - Stimulus (a): assert rst while in COUNT with remaining=4.
  - Required response (a): all outputs are 0 the next cycle and no done is seen.
  - Stimulus (b): drive a tick in the granting cycle.
  - Required response (b): remaining keeps the full loaded value.
